// File: rtl/btn_event_encoder_if.sv
// Event stream handshake between the button event encoder and its consumer.
interface btn_event_encoder_if #(
    parameter int IDX_WIDTH = 3
);
    logic                 evt_valid;
    logic                 evt_ready;
    logic [IDX_WIDTH-1:0] evt_idx;
    logic [1:0]           evt_type;

    modport master (
        output evt_valid,
        output evt_idx,
        output evt_type,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        input  evt_type,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_encoder.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events,
// one single-entry pending slot per button feeding a shared event FIFO.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | button released, hold counter parked at zero
// ST_PRESSED | button down, counting towards the LONG terminal count
// ST_HELD    | LONG reported, counting towards each REPEAT terminal count
module btn_event_encoder #(
    parameter int WIDTH        = 5,
    parameter int IDX_WIDTH    = 3,
    parameter int CNT_WIDTH    = 26,
    parameter int LONG_TICKS   = 50000000,
    parameter int REPEAT_TICKS = 10000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    btn_level,
    input  logic                overflow_clr,
    output logic                overflow,
    btn_event_encoder_if.master evt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LONG_TC = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] REP_TC  = CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam bit                   REP_EN  = (REPEAT_TICKS != 0);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [WIDTH-1:0]     btn_q;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    state_t               state [WIDTH];
    logic [CNT_WIDTH-1:0] cnt   [WIDTH];

    logic [WIDTH-1:0]     gen_v;
    logic [1:0]           gen_t [WIDTH];
    logic [WIDTH-1:0]     pend_v;
    logic [1:0]           pend_t [WIDTH];
    logic [WIDTH-1:0]     grant_vec;
    logic [WIDTH-1:0]     drop;
    logic                 grant_any;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [1:0]           grant_type;

    logic [IDX_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [IDX_WIDTH+1:0] head;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 wr_en;
    logic                 rd_en;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    // Release outranks a coincident LONG/REPEAT terminal count.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gen_v[i] = 1'b0;
            gen_t[i] = EVT_PRESS;
            case (state[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EVT_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (fall[i]) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EVT_RELEASE;
                    end else if (cnt[i] == LONG_TC) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EVT_LONG;
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EVT_RELEASE;
                    end else if (REP_EN && (cnt[i] == REP_TC)) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EVT_REPEAT;
                    end
                end
                default: begin
                    gen_v[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            btn_q <= btn_level;
            for (int i = 0; i < WIDTH; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        cnt[i] <= '0;
                        if (rise[i]) begin
                            state[i] <= ST_PRESSED;
                        end
                    end
                    ST_PRESSED: begin
                        if (fall[i]) begin
                            state[i] <= ST_IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == LONG_TC) begin
                            state[i] <= ST_HELD;
                            cnt[i]   <= '0;
                        end else if (cnt[i] != CNT_MAX) begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (fall[i]) begin
                            state[i] <= ST_IDLE;
                            cnt[i]   <= '0;
                        end else if (REP_EN && (cnt[i] == REP_TC)) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] != CNT_MAX) begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= ST_IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Lowest occupied index wins; a read in the same cycle frees room in a full FIFO.
    always_comb begin
        grant_idx  = '0;
        grant_type = EVT_PRESS;
        grant_vec  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_v[i]) begin
                grant_idx  = IDX_WIDTH'(i);
                grant_type = pend_t[i];
            end
        end
        grant_any = |pend_v;
        wr_en     = grant_any && (!fifo_full || rd_en);
        for (int i = 0; i < WIDTH; i++) begin
            grant_vec[i] = wr_en && (grant_idx == IDX_WIDTH'(i));
        end
        drop = gen_v & pend_v & ~grant_vec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                pend_t[i] <= EVT_PRESS;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (gen_v[i] && !drop[i]) begin
                    pend_v[i] <= 1'b1;
                    pend_t[i] <= gen_t[i];
                end else if (grant_vec[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
            if (|drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {grant_idx, grant_type};
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en      = !fifo_empty && evt.evt_ready;
    assign head       = mem[rd_ptr[AW-1:0]];

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_idx   = fifo_empty ? '0 : head[IDX_WIDTH+1:2];
    assign evt.evt_type  = fifo_empty ? 2'b00 : head[1:0];

endmodule

// File: doc/btn_event_encoder.md
BTN_EVENT_ENCODER -- requirements
Module: btn_event_encoder

Interface
REQ-001 Parameter WIDTH, default 5: number of debounced button lines.
REQ-002 Parameter IDX_WIDTH, default 3: event index width, ceil(log2(WIDTH)), minimum 1.
REQ-003 Parameter CNT_WIDTH, default 26: width of each per-button hold counter.
REQ-004 Parameter LONG_TICKS, default 50000000: cycles held in PRESSED before a LONG event.
REQ-005 Parameter REPEAT_TICKS, default 10000000: cycles between REPEAT events in HELD; 0 disables REPEAT.
REQ-006 Parameter FIFO_DEPTH, default 4: event queue entries, a power of 2.
REQ-007 clk input 1: rising-edge clock.
REQ-008 reset_n input 1: asynchronous, active-low reset.
REQ-009 btn_level input WIDTH: debounced button levels, active high, synchronous to clk.
REQ-010 evt_ready input 1: consumer accepts the head event when it is high and evt_valid is high.
REQ-011 evt_valid output 1: the head of the queue is valid.
REQ-012 evt_idx output IDX_WIDTH: button index of the head event.
REQ-013 evt_type output 2: event type; 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
REQ-014 overflow_clr input 1: synchronous clear of overflow.
REQ-015 overflow output 1: sticky flag set when an event was dropped.

Function
REQ-016 The block SHALL register btn_level into btn_q each cycle and define rise = btn_level & ~btn_q and fall = ~btn_level & btn_q.
REQ-017 Each button SHALL have an FSM {IDLE, PRESSED, HELD} and a CNT_WIDTH hold counter.
REQ-018 FSM transitions SHALL be evaluated in this priority order:
- fall in PRESSED or HELD -> IDLE, generate RELEASE, counter cleared.
- rise in IDLE -> PRESSED, generate PRESS, counter = 0.
- PRESSED with counter == LONG_TICKS-1 -> HELD, generate LONG, counter = 0; otherwise counter + 1.
- HELD, REPEAT_TICKS != 0, counter == REPEAT_TICKS-1 -> generate REPEAT, counter = 0; otherwise counter + 1, saturating at all-ones.
REQ-019 A release coinciding with a LONG or REPEAT terminal count SHALL generate only RELEASE.
REQ-020 A generated event SHALL be latched into that button's single-entry pending slot (valid bit plus 2-bit type) on the same clock edge.
REQ-021 If the pending slot is still occupied when a new event for that button is generated:
- the new event is dropped;
- the old event is kept;
- overflow is set to 1.
REQ-022 Each cycle the FIFO is not full, the arbiter SHALL move the lowest-index occupied pending slot into the FIFO and clear that slot.
REQ-023 If a slot is cleared by the arbiter and a new event arrives for the same button in the same cycle, the slot SHALL load the new event and SHALL NOT set overflow.
REQ-024 Latency SHALL be exactly 2 cycles from the edge that samples a rise to evt_valid high, given an empty FIFO and no competing slots.
REQ-025 FIFO write and read in the same cycle SHALL both occur; this includes the full case, where a read frees the entry for the write.
REQ-026 While the FIFO is full, no write SHALL occur and pending slots SHALL hold.
REQ-027 evt_idx and evt_type SHALL be stable while evt_valid is high and evt_ready is low.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit for full/empty distinction.
REQ-029 overflow SHALL stay 1 until overflow_clr is high; if clear and set happen in the same cycle, set wins.
REQ-030 Per-button counters SHALL NOT wrap.

Reset
REQ-031 On reset_n low the block SHALL clear, asynchronously: every FSM to IDLE, all counters, btn_q, pending slots and FIFO pointers.
REQ-032 During reset the outputs SHALL be evt_valid=0, evt_idx=0, evt_type=00, overflow=0.
REQ-033 A button held high when reset is released SHALL generate PRESS on the first cycle, since btn_q is 0.
REQ-034 Reset asserted mid-event SHALL discard all queued and pending events.

Verification
REQ-035 Press/release with LONG_TICKS=8 and evt_ready=1:
- btn_level[2] high at cycle 0 -> PRESS idx=2 valid at cycle 2;
- drop at cycle 5 -> RELEASE idx=2, with no LONG.
REQ-036 Long and repeat with LONG_TICKS=8, REPEAT_TICKS=4:
- hold btn 0 for 20 cycles -> PRESS, then LONG 8 cycles later, then REPEAT every 4 cycles;
- then RELEASE.
REQ-037 Arbitration: btn 4 and btn 1 rise in the same cycle -> PRESS idx=1, then PRESS idx=4 on consecutive cycles.
REQ-038 Backpressure with evt_ready=0 and FIFO_DEPTH=4:
- generate 5 events on distinct buttons -> 4 queued, 1 held pending, overflow=0;
- raise evt_ready -> all 5 delivered in index/arrival order.
REQ-039 Overflow with evt_ready=0, FIFO full, btn 3 pending PRESS:
- release btn 3 -> overflow=1, PRESS retained;
- overflow_clr pulse -> overflow=0.
REQ-040 Reset mid-operation: assert reset_n low with 3 events queued -> evt_valid=0 immediately; after release no stale events appear.
